mul_seq_controller: RTL and testbench
=====================================

// Module: mul_seq_controller
// PURPOSE
//  Control FSM for the sequential shift-add multiplier; sits directly upstream of the
//  product register and drives its W_ctrl / SRL_ctrl / Ready inputs.
//  Sequences one LOAD cycle, then WIDTH add/shift iterations, then holds a completion flag.
//  Decides on each iteration whether the ALU sum is written back, using the product LSB.
// PARAMETERS
//  WIDTH   32                  operand width; also the iteration count
//  CNT_W   $clog2(WIDTH)       iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  Reset       in   1      asynchronous, active-low reset
//  Run         in   1      start request; sampled only in IDLE or DONE
//  Product_lsb in   1      Product_out[0] from the product register
//  W_ctrl      out  1      load multiplier into product low half (LOAD state only)
//  SRL_ctrl    out  1      write ALU sum to product high half this iteration
//  Shift_en    out  1      product register shifts right by 1 this cycle
//  Ready       out  1      result valid in product register
//  Iter        out  CNT_W  current iteration index, 0..WIDTH-1
// BEHAVIOUR
//  - Reset (Reset==0, async): state=IDLE, Iter=0; W_ctrl=SRL_ctrl=Shift_en=Ready=0.
//  - States: IDLE, LOAD, CALC, DONE (2-bit encoded register).
//  - IDLE: all outputs 0. Run==1 at edge -> LOAD.
//  - LOAD: one cycle, W_ctrl=1, Iter cleared to 0. Always -> CALC.
//  - CALC: Shift_en=1; SRL_ctrl = Product_lsb (combinational, gated by CALC).
//    Iter increments each cycle; at Iter==WIDTH-1 -> DONE, Iter holds at WIDTH-1.
//  - DONE: Ready=1 (Moore, decoded from state), held until Run; Run==1 -> LOAD
//    (Ready drops in that same LOAD cycle).
//  - Latency: Run sampled at edge k -> LOAD in cycle k+1, CALC k+2..k+WIDTH+1,
//    Ready first high in cycle k+WIDTH+2.
//  - Run while in LOAD or CALC: ignored; no restart, no abort.
//  - Run held high continuously: back-to-back ops, DONE lasts exactly one cycle.
//  - Reset asserted mid-CALC: immediate return to IDLE, all outputs 0; the
//    partial product is discarded (the product register is not cleared here).
//  - W_ctrl, Shift_en, SRL_ctrl never high outside their states; W_ctrl and
//    Shift_en never high in the same cycle.
//  - Product_lsb is ignored outside CALC; X on it outside CALC must not propagate.
// STRUCTURE
//  - Shared include mul_defs.vh: state encodings (S_IDLE=0,S_LOAD=1,S_CALC=2,
//    S_DONE=3), default WIDTH; also used by the product register and the bench.
//  - Sub-module mul_iter_counter: CNT_W-bit counter with clear/enable and
//    terminal-count output (Iter==WIDTH-1); FSM uses tc to leave CALC.
//  - Top: state register (async active-low reset), next-state logic, output decode.
// TESTING
//  1 Reset: Reset=0 mid-sim with Run=1 -> all outputs 0, state IDLE, Iter=0 immediately
//    (no clock edge needed).
//  2 Single op WIDTH=32: Run pulse at edge 0 -> W_ctrl high cycle 1 only, Shift_en high
//    cycles 2..33, Ready high from cycle 34 until next Run.
//  3 LSB pattern: multiplier 0x0000_0005 via bench product model -> SRL_ctrl high in
//    CALC iterations 0 and 2 only; full 3*5 yields 64'd15 at Ready.
//  4 Run asserted during CALC (iteration 10) -> no effect; Ready still at cycle 34.
//  5 Run held high -> ops back-to-back, Ready high exactly 1 cycle per op, period 34.
//  6 Reset asserted in CALC iteration 17, released, new Run -> fresh 34-cycle op,
//    0xFFFF_FFFF*0xFFFF_FFFF = 64'hFFFF_FFFE_0000_0001.

Source files
------------

// File: rtl/mul_seq_controller_pkg.sv
// Shared definitions for the sequential shift-add multiplier control path.
package mul_seq_controller_pkg;

  // Default operand width; also the number of add/shift iterations.
  localparam int unsigned DEF_WIDTH = 32;

  // Controller state encoding, shared with the product register and the bench.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_seq_controller_iter_counter.sv
// Iteration counter for the multiplier controller: synchronous clear,
// count enable, saturates at WIDTH-1 and flags that terminal count.
module mul_seq_controller_iter_counter
  import mul_seq_controller_pkg::*;
#(
  parameter int unsigned  WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Terminal count: the final add/shift iteration is in progress.
  assign tc_c = (cnt == LAST);

  // Count register; clear wins over enable, holds once the last index is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_seq_controller.sv
// Control FSM for the sequential shift-add multiplier. Sequences one LOAD
// cycle, WIDTH add/shift iterations and a held completion flag, and drives
// the product register's load / write-back / shift controls.
module mul_seq_controller
  import mul_seq_controller_pkg::*;
#(
  parameter int unsigned  WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Product_lsb,
  output logic             W_ctrl,
  output logic             SRL_ctrl,
  output logic             Shift_en,
  output logic             Ready,
  output logic [CNT_W-1:0] Iter
);

  state_e state;
  state_e state_nxt;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  // Iteration index; cleared on entry to LOAD so it reads 0 for the whole LOAD cycle.
  mul_seq_controller_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (Iter),
    .tc_c  (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; Product_lsb only reaches SRL_ctrl in CALC,
  // so an unknown LSB elsewhere cannot leak onto the write-back control.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    W_ctrl    = 1'b0;
    SRL_ctrl  = 1'b0;
    Shift_en  = 1'b0;
    Ready     = 1'b0;
    case (state)
      S_IDLE: begin
        if (Run) begin
          state_nxt = S_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        W_ctrl    = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        Shift_en = 1'b1;
        SRL_ctrl = Product_lsb;
        cnt_en   = 1'b1;
        if (cnt_tc) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Ready = 1'b1;
        if (Run) begin
          state_nxt = S_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq_controller.sv
// Bench for mul_seq_controller: a cycle-schedule reference model plus a
// behavioural product register closing the loop through Product_lsb.
module tb_mul_seq_controller;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W);
  localparam int          PERIOD = int'(W) + 2;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Run = 1'b0;
  logic          Product_lsb;
  logic          W_ctrl;
  logic          SRL_ctrl;
  logic          Shift_en;
  logic          Ready;
  logic [CW-1:0] Iter;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_seq_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Run         (Run),
    .Product_lsb (Product_lsb),
    .W_ctrl      (W_ctrl),
    .SRL_ctrl    (SRL_ctrl),
    .Shift_en    (Shift_en),
    .Ready       (Ready),
    .Iter        (Iter)
  );

  // Reference schedule: m_t = cycles since the op started (0 = load,
  // 1..W = iterations), -1 when not busy; m_ready = a result is being held.
  int m_t     = -1;
  bit m_ready = 1'b0;
  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      m_t     <= -1;
      m_ready <= 1'b0;
    end else if (m_t < 0) begin
      if (Run) begin
        m_t     <= 0;
        m_ready <= 1'b0;
      end
    end else if (m_t == int'(W)) begin
      m_t     <= -1;
      m_ready <= 1'b1;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic          exp_w;
  logic          exp_sh;
  logic          exp_rdy;
  logic [CW-1:0] exp_iter;
  always_comb begin
    exp_w   = (m_t == 0);
    exp_sh  = (m_t >= 1);
    exp_rdy = (m_t < 0) && m_ready;
    if (m_t >= 1)    exp_iter = CW'(m_t - 1);
    else if (exp_rdy) exp_iter = CW'(W - 1);
    else             exp_iter = '0;
  end

  // Behavioural product register driven by the DUT controls.
  logic [W-1:0]   mcand  = '0;
  logic [W-1:0]   mplier = '0;
  logic [2*W-1:0] prod   = 'x;
  logic [W:0]     psum;
  bit s_w, s_sh, s_srl;

  assign psum        = {1'b0, prod[2*W-1:W]} + {1'b0, mcand};
  assign Product_lsb = exp_sh ? prod[0] : 1'bx;

  always @(negedge clk) begin
    s_w   = W_ctrl;
    s_sh  = Shift_en;
    s_srl = SRL_ctrl;
  end

  always @(posedge clk) begin
    if (s_w)       prod <= {{W{1'b0}}, mplier};
    else if (s_sh) prod <= s_srl ? {psum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};
  end

  // Launch one op and observe it until Ready; optionally pulse Run during iteration poke.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke,
                        output int lat, output logic [W-1:0] mask,
                        output logic [2*W-1:0] p, output int lock_bad, output int first_bad);
    bit poked;
    lat = -1; mask = '0; p = '0; lock_bad = 0; first_bad = -1; poked = 1'b0;
    @(negedge clk);
    mcand = a; mplier = b; Run = 1'b1;
    for (int c = 1; c <= 3 * int'(W); c++) begin
      @(negedge clk);
      Run = 1'b0;
      if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !==
          {exp_w, exp_sh & prod[0], exp_sh, exp_rdy, exp_iter}) begin
        lock_bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (Shift_en === 1'b1) mask[Iter] = SRL_ctrl;
      if (poke >= 0 && !poked && Shift_en === 1'b1 && Iter == CW'(poke)) begin
        Run = 1'b1; poked = 1'b1;
      end
      if (Ready === 1'b1) begin
        lat = c; p = prod; break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !== '0) begin
      bad++; $display("FAIL reset_hold outputs=%b want=0", {W_ctrl, SRL_ctrl, Shift_en, Ready, Iter});
    end
    Run = 1'b0; Reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !== '0) begin
      bad++; $display("FAIL reset_idle outputs=%b want=0", {W_ctrl, SRL_ctrl, Shift_en, Ready, Iter});
    end
  endtask

  task automatic test_single_op();
    int lat, lb, fb; logic [W-1:0] mask, a, b; logic [2*W-1:0] p;
    a = $urandom; b = $urandom;
    run_op(a, b, -1, lat, mask, p, lb, fb);
    total++; if (lat !== PERIOD) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, PERIOD); end
    total++; if (lb !== 0) begin bad++; $display("FAIL single_lockstep bad_cycles=%0d first=%0d want=0", lb, fb); end
    total++; if (p !== 64'(a) * 64'(b)) begin bad++; $display("FAIL single_product got=%h want=%h", p, 64'(a) * 64'(b)); end
    // Ready must stay high while Run is low.
    repeat (5) @(negedge clk);
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL single_ready_hold got=%b want=1", Ready); end
  endtask

  task automatic test_lsb_pattern();
    int lat, lb, fb; logic [W-1:0] mask; logic [2*W-1:0] p;
    run_op(32'd3, 32'h0000_0005, -1, lat, mask, p, lb, fb);
    total++; if (mask !== 32'h0000_0005) begin bad++; $display("FAIL lsb_mask got=%h want=%h", mask, 32'h5); end
    total++; if (p !== 64'd15) begin bad++; $display("FAIL lsb_product got=%h want=%h", p, 64'd15); end
    total++; if (lb !== 0) begin bad++; $display("FAIL lsb_lockstep bad_cycles=%0d first=%0d want=0", lb, fb); end
  endtask

  task automatic test_run_during_calc();
    int lat, lb, fb; logic [W-1:0] mask, a, b; logic [2*W-1:0] p;
    a = $urandom; b = $urandom;
    run_op(a, b, 10, lat, mask, p, lb, fb);
    total++; if (lat !== PERIOD) begin bad++; $display("FAIL calc_run_latency got=%0d want=%0d", lat, PERIOD); end
    total++; if (lb !== 0) begin bad++; $display("FAIL calc_run_lockstep bad_cycles=%0d first=%0d want=0", lb, fb); end
    total++; if (p !== 64'(a) * 64'(b)) begin bad++; $display("FAIL calc_run_product got=%h want=%h", p, 64'(a) * 64'(b)); end
  endtask

  task automatic test_back_to_back();
    int lb, rises, longs, spc_bad, prod_bad, last_rise, waited;
    bit prev;
    lb = 0; rises = 0; longs = 0; spc_bad = 0; prod_bad = 0; last_rise = -1; prev = 1'b0;
    @(negedge clk);
    mcand = $urandom; mplier = $urandom; Run = 1'b1;
    for (int c = 1; c <= 3 * PERIOD + 8; c++) begin
      @(negedge clk);
      if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !==
          {exp_w, exp_sh & prod[0], exp_sh, exp_rdy, exp_iter}) lb++;
      if (Ready === 1'b1) begin
        if (prev) longs++;
        else begin
          rises++;
          if (last_rise >= 0 && c - last_rise != PERIOD) spc_bad++;
          last_rise = c;
          if (prod !== 64'(mcand) * 64'(mplier)) prod_bad++;
        end
      end
      prev = (Ready === 1'b1);
    end
    total++; if (lb !== 0) begin bad++; $display("FAIL b2b_lockstep bad_cycles=%0d want=0", lb); end
    total++; if (rises !== 3) begin bad++; $display("FAIL b2b_ready_count got=%0d want=3", rises); end
    total++; if (longs !== 0) begin bad++; $display("FAIL b2b_ready_width extra_cycles=%0d want=0", longs); end
    total++; if (spc_bad !== 0) begin bad++; $display("FAIL b2b_period bad_gaps=%0d want=0", spc_bad); end
    total++; if (prod_bad !== 0) begin bad++; $display("FAIL b2b_product bad_results=%0d want=0", prod_bad); end
    Run = 1'b0;
    waited = 0;
    while (Ready !== 1'b1 && waited < 2 * PERIOD) begin @(negedge clk); waited++; end
    total++; if (Ready !== 1'b1) begin bad++; $display("FAIL b2b_drain ready=%b want=1", Ready); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, lb, fb, waited; logic [W-1:0] mask; logic [2*W-1:0] p;
    @(negedge clk);
    mcand = $urandom; mplier = $urandom; Run = 1'b1;
    @(negedge clk); Run = 1'b0;
    waited = 0;
    while (!(Shift_en === 1'b1 && Iter == CW'(17)) && waited < 2 * PERIOD) begin
      @(negedge clk); waited++;
    end
    total++; if (Iter !== CW'(17)) begin bad++; $display("FAIL midreset_reach iter=%0d want=17", Iter); end
    Reset = 1'b0; Run = 1'b1;
    #1;
    total++;
    if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !== '0) begin
      bad++; $display("FAIL midreset_immediate outputs=%b want=0", {W_ctrl, SRL_ctrl, Shift_en, Ready, Iter});
    end
    Run = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    total++;
    if ({W_ctrl, SRL_ctrl, Shift_en, Ready, Iter} !== '0) begin
      bad++; $display("FAIL midreset_idle outputs=%b want=0", {W_ctrl, SRL_ctrl, Shift_en, Ready, Iter});
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, mask, p, lb, fb);
    total++; if (lat !== PERIOD) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", lat, PERIOD); end
    total++; if (p !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL midreset_product got=%h want=%h", p, 64'hFFFF_FFFE_0000_0001); end
    total++; if (lb !== 0) begin bad++; $display("FAIL midreset_lockstep bad_cycles=%0d first=%0d want=0", lb, fb); end
  endtask

  task automatic test_random();
    int lat, lb, fb, poke; logic [W-1:0] mask, a, b; logic [2*W-1:0] p;
    for (int n = 0; n < 6; n++) begin
      a = $urandom; b = $urandom;
      poke = ($urandom_range(1) == 1) ? int'($urandom_range(W - 1)) : -1;
      run_op(a, b, poke, lat, mask, p, lb, fb);
      total++; if (lat !== PERIOD) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, lat, PERIOD); end
      total++; if (p !== 64'(a) * 64'(b)) begin bad++; $display("FAIL rand%0d_product got=%h want=%h", n, p, 64'(a) * 64'(b)); end
      total++; if (mask !== b) begin bad++; $display("FAIL rand%0d_mask got=%h want=%h", n, mask, b); end
      total++; if (lb !== 0) begin bad++; $display("FAIL rand%0d_lockstep bad_cycles=%0d first=%0d want=0", n, lb, fb); end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_lsb_pattern();
    test_run_during_calc();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
